// File: rtl/core_sequencer_if.sv
// Sequencer-facing bundle: memory handshake, datapath controls and status.
// The sequencer uses the master view; the surrounding system uses the slave view.
interface core_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic [31:0]       alu_result;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read_en;
  logic              mem_write_en;
  logic [31:0]       ir;
  logic              rf_chip_en;
  logic              rf_write_en_n;
  logic              alu_src;
  logic              wb_sel;
  logic              busy;
  logic              halted;
  logic              illegal;
  logic [15:0]       retired;

  modport master (
    input  start, mem_ready, mem_rdata, alu_result,
    output mem_addr, mem_read_en, mem_write_en, ir, rf_chip_en, rf_write_en_n,
           alu_src, wb_sel, busy, halted, illegal, retired
  );

  modport slave (
    output start, mem_ready, mem_rdata, alu_result,
    input  mem_addr, mem_read_en, mem_write_en, ir, rf_chip_en, rf_write_en_n,
           alu_src, wb_sel, busy, halted, illegal, retired
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for a small RV32 subset.
// All outputs are registers loaded from the decode of the next state.
module core_sequencer #(
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  core_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [15:0]       retired_q, retired_d;
  logic              illegal_q, illegal_d;
  logic              retire_s;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_read_en_q, mem_read_en_d;
  logic              mem_write_en_q, mem_write_en_d;
  logic              rf_chip_en_q, rf_chip_en_d;
  logic              rf_write_en_n_q, rf_write_en_n_d;
  logic              alu_src_q, alu_src_d;
  logic              wb_sel_q, wb_sel_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;

  logic is_r_s, is_i_s, is_lw_s, is_sw_s, is_sys_s, legal_s;

  // ir only changes on a fetch-completion edge, so classify from the register
  assign is_r_s   = (ir_q[6:0] == OP_R);
  assign is_i_s   = (ir_q[6:0] == OP_I);
  assign is_lw_s  = (ir_q[6:0] == OP_LW);
  assign is_sw_s  = (ir_q[6:0] == OP_SW);
  assign is_sys_s = (ir_q[6:0] == OP_SYS);
  assign legal_s  = is_r_s | is_i_s | is_lw_s | is_sw_s | is_sys_s;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    retire_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (bus.mem_ready) begin
          ir_d    = bus.mem_rdata;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (is_sys_s) begin
          state_d = S_HALT;
        end else if (!legal_s) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (is_lw_s || is_sw_s) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM: begin
        if (!bus.mem_ready) begin
          state_d = S_MEM;
        end else if (is_lw_s) begin
          state_d = S_WRITEBACK;
        end else begin
          state_d  = S_FETCH;
          retire_s = 1'b1;
        end
      end
      S_WRITEBACK: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    if (retire_s) begin
      pc_d = pc_q + ADDR_W'(3'd4);
    end else begin
      pc_d = pc_d;
    end
    if (retire_s && (retired_q != 16'hFFFF)) begin
      retired_d = retired_q + 16'd1;
    end else begin
      retired_d = retired_q;
    end
  end

  // Output values the sequencer presents once it has entered state_d
  always_comb begin
    mem_addr_d      = '0;
    mem_read_en_d   = 1'b0;
    mem_write_en_d  = 1'b0;
    rf_chip_en_d    = 1'b0;
    rf_write_en_n_d = 1'b1;
    alu_src_d       = 1'b0;
    wb_sel_d        = 1'b0;
    busy_d          = 1'b0;
    halted_d        = 1'b0;
    case (state_d)
      S_FETCH: begin
        busy_d        = 1'b1;
        mem_addr_d    = pc_d;
        mem_read_en_d = 1'b1;
      end
      S_DECODE: begin
        busy_d       = 1'b1;
        rf_chip_en_d = 1'b1;
      end
      S_EXECUTE: begin
        busy_d       = 1'b1;
        rf_chip_en_d = 1'b1;
        alu_src_d    = ~is_r_s;
      end
      S_MEM: begin
        busy_d         = 1'b1;
        alu_src_d      = 1'b1;
        mem_addr_d     = bus.alu_result[ADDR_W-1:0];
        mem_read_en_d  = is_lw_s;
        mem_write_en_d = is_sw_s;
      end
      S_WRITEBACK: begin
        busy_d          = 1'b1;
        rf_chip_en_d    = 1'b1;
        wb_sel_d        = is_lw_s;
        rf_write_en_n_d = (ir_q[11:7] == 5'd0);
      end
      S_HALT:  halted_d = 1'b1;
      default: halted_d = 1'b0;
    endcase
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      pc_q            <= '0;
      ir_q            <= 32'd0;
      retired_q       <= 16'd0;
      illegal_q       <= 1'b0;
      mem_addr_q      <= '0;
      mem_read_en_q   <= 1'b0;
      mem_write_en_q  <= 1'b0;
      rf_chip_en_q    <= 1'b0;
      rf_write_en_n_q <= 1'b1;
      alu_src_q       <= 1'b0;
      wb_sel_q        <= 1'b0;
      busy_q          <= 1'b0;
      halted_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      ir_q            <= ir_d;
      retired_q       <= retired_d;
      illegal_q       <= illegal_d;
      mem_addr_q      <= mem_addr_d;
      mem_read_en_q   <= mem_read_en_d;
      mem_write_en_q  <= mem_write_en_d;
      rf_chip_en_q    <= rf_chip_en_d;
      rf_write_en_n_q <= rf_write_en_n_d;
      alu_src_q       <= alu_src_d;
      wb_sel_q        <= wb_sel_d;
      busy_q          <= busy_d;
      halted_q        <= halted_d;
    end
  end

  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_read_en   = mem_read_en_q;
  assign bus.mem_write_en  = mem_write_en_q;
  assign bus.ir            = ir_q;
  assign bus.rf_chip_en    = rf_chip_en_q;
  assign bus.rf_write_en_n = rf_write_en_n_q;
  assign bus.alu_src       = alu_src_q;
  assign bus.wb_sel        = wb_sel_q;
  assign bus.busy          = busy_q;
  assign bus.halted        = halted_q;
  assign bus.illegal       = illegal_q;
  assign bus.retired       = retired_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboarded bench: each stimulus cycle queues the expected output snapshot,
// a negedge monitor pops and compares it against the selected sequencer.
module tb_core_sequencer;

  typedef enum {P_IDLE, P_FETCH, P_DEC, P_EXR, P_EXI, P_MEMR, P_MEMW,
                P_WB, P_WB0, P_WBL, P_HALT} phase_e;

  typedef struct packed {
    logic        busy;
    logic        halted;
    logic        illegal;
    logic        rd;
    logic        wr;
    logic        rfce;
    logic        rfwe_n;
    logic        alu_src;
    logic        wb_sel;
    logic [7:0]  addr;
    logic [15:0] retired;
    logic [31:0] ir;
  } obs_t;

  localparam logic [31:0] ADD   = 32'h002081B3;
  localparam logic [31:0] LW    = 32'h00802283;
  localparam logic [31:0] SW    = 32'h00202023;
  localparam logic [31:0] ECALL = 32'h00000073;
  localparam logic [31:0] BAD   = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] alu_result = 32'd0;
  logic        sel = 1'b0;
  string       tname = "reset";
  int          n_vec = 0;
  int          n_bad = 0;
  obs_t        exp_q[$];
  obs_t        obs_a, obs_b;

  core_sequencer_if #(.ADDR_W(8)) bus_a ();
  core_sequencer_if #(.ADDR_W(4)) bus_b ();

  core_sequencer #(.ADDR_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  core_sequencer #(.ADDR_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  assign bus_a.start = start;       assign bus_b.start = start;
  assign bus_a.mem_ready = mem_ready; assign bus_b.mem_ready = mem_ready;
  assign bus_a.mem_rdata = mem_rdata; assign bus_b.mem_rdata = mem_rdata;
  assign bus_a.alu_result = alu_result; assign bus_b.alu_result = alu_result;

  assign obs_a = {bus_a.busy, bus_a.halted, bus_a.illegal, bus_a.mem_read_en,
                  bus_a.mem_write_en, bus_a.rf_chip_en, bus_a.rf_write_en_n,
                  bus_a.alu_src, bus_a.wb_sel, bus_a.mem_addr, bus_a.retired, bus_a.ir};
  assign obs_b = {bus_b.busy, bus_b.halted, bus_b.illegal, bus_b.mem_read_en,
                  bus_b.mem_write_en, bus_b.rf_chip_en, bus_b.rf_write_en_n,
                  bus_b.alu_src, bus_b.wb_sel, 4'h0, bus_b.mem_addr, bus_b.retired, bus_b.ir};

  always #5 clk = ~clk;

  // Expected outputs for one cycle spent in the named phase
  function automatic obs_t model(phase_e p, logic [7:0] a, logic [31:0] irv,
                                 logic [15:0] r, logic il);
    obs_t o;
    o = '0;
    o.rfwe_n = 1'b1;
    o.ir = irv;
    o.retired = r;
    o.illegal = il;
    case (p)
      P_FETCH: begin o.busy = 1'b1; o.rd = 1'b1; o.addr = a; end
      P_DEC, P_EXR: begin o.busy = 1'b1; o.rfce = 1'b1; end
      P_EXI: begin o.busy = 1'b1; o.rfce = 1'b1; o.alu_src = 1'b1; end
      P_MEMR: begin o.busy = 1'b1; o.alu_src = 1'b1; o.rd = 1'b1; o.addr = a; end
      P_MEMW: begin o.busy = 1'b1; o.alu_src = 1'b1; o.wr = 1'b1; o.addr = a; end
      P_WB: begin o.busy = 1'b1; o.rfce = 1'b1; o.rfwe_n = 1'b0; end
      P_WB0: begin o.busy = 1'b1; o.rfce = 1'b1; end
      P_WBL: begin o.busy = 1'b1; o.rfce = 1'b1; o.rfwe_n = 1'b0; o.wb_sel = 1'b1; end
      P_HALT: o.halted = 1'b1;
      default: o.busy = 1'b0;
    endcase
    return o;
  endfunction

  task automatic cyc(phase_e p, logic [7:0] a, logic [31:0] irv, logic [15:0] r,
                     logic il, logic st, logic rdy, logic [31:0] rd);
    @(posedge clk); #1;
    exp_q.push_back(model(p, a, irv, r, il));
    start = st;
    mem_ready = rdy;
    mem_rdata = rd;
  endtask

  // One cycle with rst_n driven to rv; outputs must read as reset values
  task automatic rcyc(logic rv, logic rdy);
    @(posedge clk); #1;
    rst_n = rv;
    start = 1'b0;
    mem_ready = rdy;
    exp_q.push_back(model(P_IDLE, 8'h00, 32'd0, 16'd0, 1'b0));
  endtask

  always @(negedge clk) begin
    obs_t e, got;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      got = sel ? obs_b : obs_a;
      n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL %s vec=%0d got=%h exp=%h (busy,halt,ill,rd,wr,rfce,rfwe_n,alu,wb,addr,ret,ir)",
                 tname, n_vec, got, e);
      end
    end
  end

  initial begin
    logic [31:0] prog [4];
    logic [7:0]  pcs  [4];
    phase_e      wbp  [4];
    logic [31:0] prev;
    prog = '{32'h00100093, 32'h00000013, 32'h00200113, 32'h00300193};
    pcs  = '{8'h0, 8'h4, 8'h8, 8'hC};
    wbp  = '{P_WB, P_WB0, P_WB, P_WB};

    rcyc(1'b0, 1'b0);
    rcyc(1'b1, 1'b0);

    tname = "add";
    alu_result = 32'h0000_0008;
    cyc(P_IDLE,  8'h00, 32'd0, 16'd0, 1'b0, 1'b1, 1'b1, ADD);
    cyc(P_FETCH, 8'h00, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1, ADD);
    cyc(P_DEC,   8'h00, ADD,   16'd0, 1'b0, 1'b0, 1'b1, 32'd0);
    cyc(P_EXR,   8'h00, ADD,   16'd0, 1'b0, 1'b0, 1'b1, 32'd0);
    cyc(P_WB,    8'h00, ADD,   16'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    tname = "lw_wait";
    cyc(P_FETCH, 8'h04, ADD, 16'd1, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(P_FETCH, 8'h04, ADD, 16'd1, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(P_FETCH, 8'h04, ADD, 16'd1, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(P_FETCH, 8'h04, ADD, 16'd1, 1'b0, 1'b0, 1'b1, LW);
    cyc(P_DEC,   8'h00, LW,  16'd1, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(P_EXI,   8'h00, LW,  16'd1, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(P_MEMR,  8'h08, LW,  16'd1, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(P_MEMR,  8'h08, LW,  16'd1, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(P_MEMR,  8'h08, LW,  16'd1, 1'b0, 1'b0, 1'b1, 32'd0);
    cyc(P_WBL,   8'h00, LW,  16'd1, 1'b0, 1'b0, 1'b1, SW);

    tname = "sw_ecall";
    alu_result = 32'h0000_0020;
    cyc(P_FETCH, 8'h08, LW,    16'd2, 1'b0, 1'b0, 1'b1, SW);
    cyc(P_DEC,   8'h00, SW,    16'd2, 1'b0, 1'b0, 1'b1, 32'd0);
    cyc(P_EXI,   8'h00, SW,    16'd2, 1'b0, 1'b0, 1'b1, 32'd0);
    cyc(P_MEMW,  8'h20, SW,    16'd2, 1'b0, 1'b0, 1'b1, ECALL);
    cyc(P_FETCH, 8'h0C, SW,    16'd3, 1'b0, 1'b0, 1'b1, ECALL);
    cyc(P_DEC,   8'h00, ECALL, 16'd3, 1'b0, 1'b1, 1'b1, 32'd0);
    cyc(P_HALT,  8'h00, ECALL, 16'd3, 1'b0, 1'b1, 1'b1, ADD);
    cyc(P_HALT,  8'h00, ECALL, 16'd3, 1'b0, 1'b0, 1'b1, ADD);
    cyc(P_HALT,  8'h00, ECALL, 16'd3, 1'b0, 1'b0, 1'b0, 32'd0);

    tname = "illegal";
    rcyc(1'b0, 1'b0);
    rcyc(1'b1, 1'b0);
    cyc(P_IDLE,  8'h00, 32'd0, 16'd0, 1'b0, 1'b1, 1'b1, BAD);
    cyc(P_FETCH, 8'h00, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1, BAD);
    cyc(P_DEC,   8'h00, BAD,   16'd0, 1'b0, 1'b1, 1'b1, ADD);
    cyc(P_HALT,  8'h00, BAD,   16'd0, 1'b1, 1'b1, 1'b1, ADD);
    cyc(P_HALT,  8'h00, BAD,   16'd0, 1'b1, 1'b0, 1'b1, ADD);
    cyc(P_HALT,  8'h00, BAD,   16'd0, 1'b1, 1'b1, 1'b1, ADD);
    cyc(P_HALT,  8'h00, BAD,   16'd0, 1'b1, 1'b0, 1'b0, 32'd0);

    tname = "reset_mid_fetch";
    rcyc(1'b0, 1'b0);
    rcyc(1'b1, 1'b0);
    cyc(P_IDLE,  8'h00, 32'd0, 16'd0, 1'b0, 1'b1, 1'b0, ADD);
    cyc(P_FETCH, 8'h00, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, ADD);
    rcyc(1'b0, 1'b1);
    rcyc(1'b0, 1'b1);
    rcyc(1'b1, 1'b1);
    cyc(P_IDLE,  8'h00, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1, ADD);
    cyc(P_IDLE,  8'h00, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    tname = "addi_wrap_aw4";
    rcyc(1'b0, 1'b0);
    rcyc(1'b1, 1'b0);
    sel = 1'b1;
    prev = 32'd0;
    cyc(P_IDLE, 8'h00, 32'd0, 16'd0, 1'b0, 1'b1, 1'b1, prog[0]);
    for (int k = 0; k < 4; k++) begin
      cyc(P_FETCH, pcs[k], prev,    16'(k), 1'b0, 1'b0, 1'b1, prog[k]);
      cyc(P_DEC,   8'h00,  prog[k], 16'(k), 1'b0, 1'b0, 1'b1, 32'd0);
      cyc(P_EXI,   8'h00,  prog[k], 16'(k), 1'b0, 1'b0, 1'b1, 32'd0);
      cyc(wbp[k],  8'h00,  prog[k], 16'(k), 1'b0, 1'b0, 1'b0, 32'd0);
      prev = prog[k];
    end
    cyc(P_FETCH, 8'h00, prog[3], 16'd4, 1'b0, 1'b0, 1'b0, 32'd0);

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory byte-address width.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  begin execution from IDLE.
REQ-005 SHALL have port mem_ready  input  1  memory system access-complete handshake.
REQ-006 SHALL have port mem_rdata  input  32  memory system read data.
REQ-007 SHALL have port alu_result  input  32  datapath ALU output, used as load/store address.
REQ-008 SHALL have port mem_addr  output  ADDR_W  memory address.
REQ-009 SHALL have port mem_read_en  output  1  memory read request.
REQ-010 SHALL have port mem_write_en  output  1  memory write request.
REQ-011 SHALL have port ir  output  32  instruction register, to datapath decode.
REQ-012 SHALL have port rf_chip_en  output  1  register file enable, active-high.
REQ-013 SHALL have port rf_write_en_n  output  1  register file write enable, active-low.
REQ-014 SHALL have port alu_src  output  1  0 = rs2, 1 = immediate.
REQ-015 SHALL have port wb_sel  output  1  0 = ALU result, 1 = load data to rd.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE and HALT.
REQ-017 SHALL have port halted  output  1  high in HALT.
REQ-018 SHALL have port illegal  output  1  sticky illegal-opcode flag.
REQ-019 SHALL have port retired  output  16  count of completed instructions.

Function
REQ-020 SHALL implement states IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
REQ-021 IDLE -> FETCH when start=1, with pc cleared to 0 on that edge; start SHALL be ignored in every other state.
REQ-022 FETCH: mem_addr=pc, mem_read_en=1 until mem_ready is sampled 1; on that edge ir<=mem_rdata and go to DECODE. Wait cycles are unbounded.
REQ-023 DECODE: rf_chip_en=1, rf_write_en_n=1; classify ir[6:0]: 0110011 R-ALU, 0010011 I-ALU, 0000011 LW, 0100011 SW, 1110011 SYSTEM; anything else illegal.
REQ-024 DECODE exits: SYSTEM -> HALT; illegal -> HALT with illegal<=1; otherwise -> EXECUTE.
REQ-025 EXECUTE: rf_chip_en=1, rf_write_en_n=1, alu_src=0 for R-ALU, 1 for I-ALU/LW/SW; R/I -> WRITEBACK, LW/SW -> MEM.
REQ-026 MEM: alu_src=1, mem_addr=alu_result[ADDR_W-1:0]; LW drives mem_read_en=1, SW drives mem_write_en=1, each held until mem_ready=1.
REQ-027 MEM exit: LW -> WRITEBACK; SW -> FETCH, with the instruction retired on that edge.
REQ-028 WRITEBACK lasts exactly one cycle: rf_chip_en=1, wb_sel=1 for LW else 0; rf_write_en_n=0 only if ir[11:7]!=0 (x0 write suppressed).
REQ-029 WRITEBACK -> FETCH, retiring the instruction.
REQ-030 On each retire edge: pc<=pc+4 modulo 2^ADDR_W (wraps to 0), retired<=retired+1 saturating at 0xFFFF.
REQ-031 ir SHALL hold its value outside the FETCH-completion edge.
REQ-032 SYSTEM/illegal instructions SHALL NOT retire or advance pc.
REQ-033 mem_read_en and mem_write_en SHALL never be high in the same cycle.
REQ-034 Unused outputs SHALL be at their reset value in IDLE and HALT.
REQ-035 Latency with mem_ready already high: R/I = 4 cycles, LW = 5, SW = 4.
REQ-036 HALT is terminal; only rst_n leaves it.

Reset
REQ-037 rst_n=0 SHALL immediately, without a clock, force: state IDLE, pc=0, ir=0, retired=0, illegal=0, mem_addr=0, mem_read_en=0, mem_write_en=0, rf_chip_en=0, rf_write_en_n=1, alu_src=0, wb_sel=0, busy=0, halted=0.
REQ-038 Reset asserted mid-access SHALL drop the memory request in the same cycle; a mem_ready arriving after reset SHALL be ignored.

Verification
REQ-039 ADD x3,x1,x2 (0x002081B3), mem_ready=1 -> DECODE/EXECUTE/WRITEBACK, rf_write_en_n=0 one cycle, pc=4, retired=1, 4 cycles total.
REQ-040 LW x5,8(x0) with mem_ready delayed 3 cycles in FETCH and 2 in MEM -> mem_addr=0x08 in MEM, wb_sel=1 in WRITEBACK, 10 cycles total.
REQ-041 SW followed by ECALL (0x00000073) -> mem_write_en pulse, no rf write, retired=1, halted=1, pc=4.
REQ-042 opcode 0x7F -> illegal=1, halted=1, retired unchanged; start pulses ignored until reset.
REQ-043 ADDR_W=4, four back-to-back ADDI -> pc sequence 4, 8, 12, 0; ADDI x0 produces rf_write_en_n stuck at 1.
REQ-044 rst_n low while mem_read_en=1 in FETCH -> all outputs at reset values before the next edge; late mem_ready has no effect.
